sad_search_ctrl: RTL and testbench

SAD_SEARCH_CTRL -- requirements
Module: sad_search_ctrl

---
 rtl/me_pkg.sv | 16 +
 rtl/sad_search_ctrl_if.sv | 13 +
 rtl/sad_min16.sv | 17 +
 rtl/sad_search_ctrl.sv | 100 ++++++++++
 tb/tb_sad_search_ctrl.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/me_pkg.sv
// Shared constants and FSM encoding for the motion-estimation SAD search.
package me_pkg;
  localparam int SAD_W = 16;
  localparam int COLS  = 16;
  localparam int ROW_W = 4;
  localparam logic [SAD_W-1:0] SAD_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LAUNCH,
    ST_WAIT,
    ST_CMP,
    ST_DONE
  } state_t;
endpackage

// File: rtl/sad_search_ctrl_if.sv
// Reference-fetch handshake and SAD datapath bus between the search controller and the datapath.
interface sad_search_ctrl_if;
  import me_pkg::*;

  logic                   ref_req;
  logic [ROW_W-1:0]       ref_row;
  logic                   ref_ack;
  logic                   sad_en;
  logic [COLS*SAD_W-1:0]  sad_row;

  modport master (output ref_req, ref_row, sad_en, input ref_ack, sad_row);
  modport slave  (input ref_req, ref_row, sad_en, output ref_ack, sad_row);
endinterface

// File: rtl/sad_min16.sv
// Combinational minimum of 16 SADs; strict compare keeps the lowest column on ties.
module sad_min16 import me_pkg::*; (
  input  logic [COLS-1:0][SAD_W-1:0] sads,
  output logic [SAD_W-1:0]           min_val,
  output logic [ROW_W-1:0]           min_idx
);
  always_comb begin
    min_val = sads[0];
    min_idx = '0;
    for (int c = 1; c < COLS; c++) begin
      if (sads[c] < min_val) begin
        min_val = sads[c];
        min_idx = ROW_W'(c);
      end
    end
  end
endmodule

// File: rtl/sad_search_ctrl.sv
// Full-window SAD search controller: fetches each reference row, launches the
// SAD datapath, and keeps the first minimum in raster order.
module sad_search_ctrl import me_pkg::*; #(
  parameter int SAD_LAT  = 2,
  parameter int NUM_ROWS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  sad_search_ctrl_if.master   dp,
  output logic                busy,
  output logic                done,
  output logic [ROW_W-1:0]    best_mv_x,
  output logic [ROW_W-1:0]    best_mv_y,
  output logic [SAD_W-1:0]    best_sad
);
  localparam logic [3:0]       LAT_LAST = 4'(SAD_LAT - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);

  state_t           state;
  logic [ROW_W-1:0] row;
  logic [3:0]       lat_cnt;
  logic             ref_req;
  logic             sad_en;
  logic [SAD_W-1:0] row_min;
  logic [ROW_W-1:0] row_min_idx;

  sad_min16 u_min (
    .sads    (dp.sad_row),
    .min_val (row_min),
    .min_idx (row_min_idx)
  );

  assign dp.ref_req = ref_req;
  assign dp.ref_row = row;
  assign dp.sad_en  = sad_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      row       <= '0;
      lat_cnt   <= '0;
      busy      <= 1'b0;
      ref_req   <= 1'b0;
      sad_en    <= 1'b0;
      done      <= 1'b0;
      best_sad  <= SAD_MAX;
      best_mv_x <= '0;
      best_mv_y <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          row       <= '0;
          best_sad  <= SAD_MAX;
          best_mv_x <= '0;
          best_mv_y <= '0;
          busy      <= 1'b1;
          ref_req   <= 1'b1;
          state     <= ST_FETCH;
        end
        ST_FETCH: if (dp.ref_ack) begin
          ref_req <= 1'b0;
          sad_en  <= 1'b1;
          state   <= ST_LAUNCH;
        end
        ST_LAUNCH: begin
          sad_en  <= 1'b0;
          lat_cnt <= '0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (lat_cnt == LAT_LAST) state <= ST_CMP;
          else                     lat_cnt <= lat_cnt + 4'd1;
        end
        ST_CMP: begin
          // Row 0 loads unconditionally so an all-0xFFFF window still reports (0,0).
          if (row == '0 || row_min < best_sad) begin
            best_sad  <= row_min;
            best_mv_x <= row_min_idx;
            best_mv_y <= row;
          end
          if (row == ROW_LAST) begin
            state <= ST_DONE;
          end else begin
            row     <= row + 1'b1;
            ref_req <= 1'b1;
            state   <= ST_FETCH;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sad_search_ctrl.sv
// Randomised bench for sad_search_ctrl against a raster-order minimum model.
module tb_sad_search_ctrl;
  import me_pkg::*;

  localparam int SAD_LAT  = 2;
  localparam int NUM_ROWS = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, done;
  logic [3:0]  best_mv_x, best_mv_y;
  logic [15:0] best_sad;

  sad_search_ctrl_if ifc ();

  sad_search_ctrl #(.SAD_LAT(SAD_LAT), .NUM_ROWS(NUM_ROWS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dp        (ifc),
    .busy      (busy),
    .done      (done),
    .best_mv_x (best_mv_x),
    .best_mv_y (best_mv_y),
    .best_sad  (best_sad)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [NUM_ROWS][COLS];
  int n_chk = 0, n_pass = 0;

  int   ack_delay = 0;
  bit   ack_noise = 1'b0;
  int   hold_err  = 0;
  int   req_cnt   = 0;
  bit   prev_req  = 1'b0, prev_ack = 1'b0;
  logic [3:0] prev_row = '0;

  int   dp_lat = 0;
  logic [3:0] dp_row = '0;
  logic [COLS*SAD_W-1:0] row_bits;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference side: acks after ack_delay extra cycles, optional ack noise outside fetch,
  // and flags any drop of ref_req or change of ref_row before the ack.
  always @(negedge clk) begin
    if (prev_req && !prev_ack && (!ifc.ref_req || ifc.ref_row != prev_row)) hold_err++;
    req_cnt = ifc.ref_req ? req_cnt + 1 : 0;
    if (ifc.ref_req) ifc.ref_ack = (req_cnt > ack_delay);
    else             ifc.ref_ack = ack_noise ? 1'($urandom_range(0, 1)) : 1'b0;
    prev_req = ifc.ref_req;
    prev_row = ifc.ref_row;
    prev_ack = ifc.ref_ack;
  end

  // SAD datapath: results read as zero until SAD_LAT cycles after the launch strobe.
  always @(negedge clk) begin
    if (ifc.sad_en) begin
      dp_lat = 0;
      dp_row = ifc.ref_row;
    end else if (dp_lat < 1000) dp_lat++;
    row_bits = '0;
    if (dp_lat >= SAD_LAT)
      for (int c = 0; c < COLS; c++) row_bits[16*c +: 16] = mem[dp_row][c];
    ifc.sad_row = row_bits;
  end

  task automatic fill(input logic [15:0] v);
    for (int y = 0; y < NUM_ROWS; y++)
      for (int x = 0; x < COLS; x++) mem[y][x] = v;
  endtask

  task automatic fill_rand(input int hi);
    for (int y = 0; y < NUM_ROWS; y++)
      for (int x = 0; x < COLS; x++) mem[y][x] = 16'($urandom_range(0, hi));
  endtask

  task automatic model(output logic [15:0] s, output logic [3:0] mx, output logic [3:0] my);
    s = mem[0][0]; mx = 0; my = 0;
    for (int y = 0; y < NUM_ROWS; y++)
      for (int x = 0; x < COLS; x++)
        if (mem[y][x] < s) begin s = mem[y][x]; mx = 4'(x); my = 4'(y); end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "busy"},     busy,        0);
    chk({p, "ref_req"},  ifc.ref_req, 0);
    chk({p, "sad_en"},   ifc.sad_en,  0);
    chk({p, "done"},     done,        0);
    chk({p, "ref_row"},  ifc.ref_row, 0);
    chk({p, "mv_x"},     best_mv_x,   0);
    chk({p, "mv_y"},     best_mv_y,   0);
    chk({p, "best_sad"}, best_sad,    16'hFFFF);
  endtask

  task automatic run_search(input int delay, input int restart_at, output int cyc, output int ndone);
    ack_delay = delay; cyc = -1; ndone = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int k = 1; k <= 4000; k++) begin
      @(negedge clk);
      start = (k == restart_at);
      if (done) begin ndone++; if (cyc < 0) cyc = k; end
      if (cyc >= 0 && k >= cyc + 5) break;
    end
    start = 1'b0;
  endtask

  task automatic check_search(input string tag, input int delay, input int restart_at);
    logic [15:0] es; logic [3:0] ex, ey;
    int cyc, nd;
    model(es, ex, ey);
    run_search(delay, restart_at, cyc, nd);
    chk({tag, "_cycles"}, cyc, NUM_ROWS * (SAD_LAT + 3 + delay) + 1);
    chk({tag, "_ndone"},  nd, 1);
    chk({tag, "_sad"},    best_sad, es);
    chk({tag, "_mv_x"},   best_mv_x, ex);
    chk({tag, "_mv_y"},   best_mv_y, ey);
    chk({tag, "_idle"},   busy, 0);
  endtask

  initial begin
    int h0, dcount;
    bit found;
    rst_n = 1'b0; start = 1'b0;
    fill(16'd0);
    repeat (3) @(negedge clk);
    chk_reset("rst_");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("release_busy", busy, 0);
    chk("release_done", done, 0);

    fill(16'd1000); mem[9][5] = 16'd37;
    check_search("peak", 0, 0);

    fill(16'd500); mem[2][3] = 16'd10; mem[2][7] = 16'd10; mem[12][0] = 16'd10;
    check_search("tie", 0, 0);

    fill_rand(200);
    h0 = hold_err;
    check_search("slow_ack", 4, 0);
    chk("slow_ack_hold", hold_err - h0, 0);

    fill_rand(300);
    check_search("restart_ign", 0, 20);

    fill(16'hFFFF);
    check_search("all_max", 0, 0);

    // Reset in the first WAIT cycle of row 6.
    fill_rand(50);
    ack_delay = 0; found = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(negedge clk);
      if (ifc.sad_en && ifc.ref_row == 4'd6) found = 1'b1;
    end
    chk("mid_row6_found", found, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset("mid_");
    dcount = 0;
    repeat (3) @(negedge clk) dcount += int'(done);
    rst_n = 1'b1;
    repeat (20) @(negedge clk) dcount += int'(done);
    chk("mid_no_done", dcount, 0);
    chk("mid_idle", busy, 0);
    check_search("after_rst", 0, 0);

    ack_noise = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fill_rand((i == 3) ? 8 : 60);
      check_search($sformatf("rand%0d", i), int'($urandom_range(0, 3)), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
